multi_timer: RTL
================

# multi_timer

Parametrised multi-channel interval timer for the traffic light controller: NCH independent channels, each counting clock cycles up to a period latched at start. Each channel runs one-shot or periodic and can be held or stopped. It generalises the fixed 3-bit short timer into the common timing resource the controller FSM uses for green, yellow, red and walk intervals.

## Interface
- WIDTH, 8, counter and period width in bits (≥1).
- NCH, 4, number of independent channels (≥1).

- clk  input  1  system clock; all state changes on the rising edge.
- arst  input  1  reset, synchronous, active-high.
- start  input  NCH  per-channel start/restart request, sampled on the rising edge.
- stop  input  NCH  per-channel abort, which returns the channel to IDLE.
- hold  input  NCH  per-channel pause: freezes the count and suppresses tick.
- mode  input  NCH  per-channel mode, latched at start: 0 = one-shot, 1 = periodic.
- period  input  NCH*WIDTH  per-channel terminal value; channel i uses bits [i*WIDTH +: WIDTH], latched at start.
- tick  output  NCH  one-cycle expiry strobe.
- done  output  NCH  level output: a one-shot channel has expired and is waiting.
- busy  output  NCH  level output: the channel is in RUN.

## Operation
- Each channel has three states (IDLE, RUN, DONE) and three registers: count[WIDTH], period_q[WIDTH] and mode_q.
- Reset:
  - All channels go to IDLE with count = 0, period_q = 0 and mode_q = 0.
  - tick, done and busy are all 0.
- Output decode:
  - tick[i] = (state == RUN) && (count == period_q) && !hold[i]. This is combinational from registers and inputs.
  - busy[i] = (state == RUN).
  - done[i] = (state == DONE).
- Next-state priority per channel, highest first: arst, then stop, then start, then hold, then expiry, then count.
  - stop[i]: go to IDLE and set count = 0. stop wins over a simultaneous start.
  - start[i]: from any state, go to RUN and set count = 0, period_q = period slice, mode_q = mode[i]. A restart in RUN discards the current interval.
  - hold[i] in RUN: count, state and latched values are unchanged. In IDLE or DONE, hold has no effect.
  - Expiry in RUN (count == period_q, no hold):
    - mode_q = 0: go to DONE; count holds at period_q.
    - mode_q = 1: stay in RUN and set count = 0.
  - Otherwise, in RUN, count increments by 1.
- Width and arithmetic:
  - count never exceeds period_q, so it cannot wrap.
  - period = 0 is legal: tick fires in the first cycle after start. In periodic mode it then fires every unheld cycle.
- DONE is left only by start, stop or arst.
- Changing period or mode while in RUN has no effect until the next start.
- A start in the same cycle as tick:
  - tick is still asserted in that cycle.
  - The restart takes precedence over reload or entry to DONE.
- Channels are fully independent; there is no shared state apart from clk and arst.

## Timing
- Start latency: start sampled at edge k gives count = 0 and busy = 1 after edge k.
- Expiry timing, no hold: tick is high for exactly the one cycle following edge k+P, where P is the latched period. That is P+1 cycles from the start edge to the tick edge, inclusive of the count-0 cycle.
- Each held cycle delays tick by exactly one cycle.
- Periodic mode: tick repeats every P+1 unheld cycles.
- One-shot mode: done rises at the edge after the tick cycle, and tick does not repeat.
- stop and arst take effect at the next edge; outputs are 0 in the following cycle.
- arst mid-interval: there is no tick and no done afterwards. The channel needs a fresh start.

## Test plan
- Reset, then start[0] with period = 7 and mode = 0 (held for one cycle) -> busy[0] = 1 for 8 cycles, tick[0] high only in cycle 8 after the start edge, then done[0] = 1 and busy[0] = 0 indefinitely.
- Periodic with period = 3 on channel 1 -> tick[1] every 4th cycle over 5 periods; done[1] stays 0.
- Channel 2 with period = 5 and hold[2] high for 3 cycles mid-count -> tick[2] delayed by exactly 3 cycles. With hold asserted while count == period_q, tick is suppressed until hold drops.
- Restart and precedence on channel 0 (period = 10):
  - start at count = 6 -> tick 11 cycles after the second start.
  - start and stop in the same cycle -> IDLE.
  - start coincident with tick -> tick seen once, then a new full interval.
- period = 0, periodic mode on channel 3 -> tick[3] high every cycle. Asserting arst mid-run -> all outputs 0 on the next cycle and the channel stays IDLE.
- All four channels started together with periods 1, 2, 3, 4 and mixed modes -> tick timing on each channel is independent and matches its period exactly.

Source files
------------

// File: rtl/multi_timer.sv
// Multi-channel interval timer: NCH independent channels, each counting cycles up
// to a period latched at start, in one-shot or periodic mode, with hold and stop.
module multi_timer #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic [NCH-1:0]       start,
  input  logic [NCH-1:0]       stop,
  input  logic [NCH-1:0]       hold,
  input  logic [NCH-1:0]       mode,
  input  logic [NCH*WIDTH-1:0] period,
  output logic [NCH-1:0]       tick,
  output logic [NCH-1:0]       done,
  output logic [NCH-1:0]       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] period_q;
    logic             mode_q;
    logic             at_end;

    // Terminal count reached; used both for the tick strobe and the expiry branch.
    assign at_end = (state_q == S_RUN) && (count_q == period_q);

    // NOTE: state registers use non-blocking assignments so every channel samples
    // its pre-edge values; blocking here would let one branch observe another's update.
    always_ff @(posedge clk) begin
      if (arst) begin
        state_q  <= S_IDLE;
        count_q  <= '0;
        period_q <= '0;
        mode_q   <= 1'b0;
      end else if (stop[i]) begin
        state_q <= S_IDLE;
        count_q <= '0;
      end else if (start[i]) begin
        state_q  <= S_RUN;
        count_q  <= '0;
        period_q <= period[i*WIDTH +: WIDTH];
        mode_q   <= mode[i];
      end else if ((state_q == S_RUN) && !hold[i]) begin
        if (at_end) begin
          // Periodic reloads in place; one-shot parks with count at period_q.
          if (mode_q) begin
            count_q <= '0;
          end else begin
            state_q <= S_DONE;
          end
        end else begin
          count_q <= count_q + ONE;
        end
      end
    end

    assign tick[i] = at_end && !hold[i];
    assign busy[i] = (state_q == S_RUN);
    assign done[i] = (state_q == S_DONE);
  end

endmodule
